wb_cpu_bus_master: RTL and testbench
====================================

Name: wb_cpu_bus_master

Overview:
- Parametrised Wishbone B4 classic master between the CPU load/store unit and the system bus (RAM, devices).
- Successor to the fixed 32-bit CPU bus adapter, adding:
  - DATA_W-wide bus with address-driven byte-lane steering;
  - misalignment detection;
  - ERR_I termination and a bus timeout;
  - an explicit done/error strobe.
- Tag accesses (BUSOP_READT/WRITET) are flagged on TGA_O instead of a special select pattern.

Parameters:
DATA_W, 32, bus data width; 32 or 64. SEL_W = DATA_W/8, LSB_W = log2(SEL_W).
ADDR_W, 32, byte-address width.
TIMEOUT, 255, cycles in BUS state before abort; 0 disables the timeout.
TO_W, 16, timeout counter width; TIMEOUT < 2^TO_W.

Ports:
CLK_I  in  1  clock; all logic on rising edge.
RST_N_I  in  1  synchronous reset, active low.
I_en  in  1  request strobe; accepted only while O_busy=0.
I_op  in  4  BUSOP_* code from busdefs.vh.
I_addr  in  ADDR_W  byte address.
I_data  in  32  store data (LSB-justified).
O_data  out  32  load result, extended; valid from O_done, held until next completion.
O_busy  out  1  transaction in progress.
O_done  out  1  one-cycle completion pulse.
O_err  out  1  with O_done: transaction failed.
O_err_code  out  2  0 none, 1 misaligned, 2 bus ERR_I, 3 timeout; held until next completion.
ADR_O  out  ADDR_W  I_addr with low LSB_W bits cleared.
DAT_O  out  DATA_W  steered store data.
SEL_O  out  SEL_W  byte-lane select.
CYC_O, STB_O, WE_O, TGA_O  out  1 each  Wishbone cycle, strobe, write enable, tag-access flag.
DAT_I  in  DATA_W  read data.
ACK_I, ERR_I  in  1 each  slave terminations.

Behaviour:
- Reset (RST_N_I=0 at an edge): all outputs 0, state IDLE, counter 0. This applies mid-transaction: CYC/STB drop at that edge and no O_done is issued.
- FSM states: IDLE, BUS, FAULT.
- IDLE, I_en=1, request aligned: latch op, drive ADR/DAT/SEL/WE/TGA, set CYC=STB=1 and busy=1, go to BUS.
- IDLE, I_en=1, request misaligned: no bus cycle; busy=1, go to FAULT.
- FAULT: next edge gives O_done=1, O_err=1, code 1, busy=0, back to IDLE.
- Alignment rules:
  - half needs addr[0]=0;
  - word needs addr[1:0]=0;
  - byte and tag are always aligned.
- BUS, each edge, in priority order:
  1. ERR_I: terminate, O_err=1, code 2.
  2. ACK_I: terminate, capture O_data, O_err=0, code 0.
  3. TIMEOUT≠0 and counter==TIMEOUT-1: terminate, O_err=1, code 3.
  4. Otherwise increment the counter.
- Terminate means:
  - CYC, STB, WE, SEL, TGA go to 0 and busy to 0;
  - O_done=1 for exactly one cycle;
  - state returns to IDLE and the counter clears.
- ACK_I/ERR_I are ignored while CYC_O=0. I_en is ignored while busy, including the done cycle's edge.
- Latency: zero-wait slave gives I_en at edge 0, CYC_O high after edge 0, ACK_I at edge 1, O_done high after edge 1. Next request is accepted at edge 2; back-to-back period is 2 cycles.
- Lane steering, with lane = I_addr[LSB_W-1:0]:
  - byte/tag: SEL = 1<<lane;
  - half: SEL = 3<<lane;
  - word: SEL = 4'hF<<lane.
- Store data is replicated across all lanes: byte x SEL_W, half x SEL_W/2, word x SEL_W/4. Tag write puts I_data[3:0] in the low nibble of each byte.
- Load data: shift DAT_I right by lane*8, then:
  - BUSOP_READB/READH sign-extend;
  - READBU/READHU zero-extend;
  - READW passes 32 bits;
  - READT returns {28'b0, byte[3:0]}.
- Unknown op code: treated as a byte read.

Test Plan:
- DATA_W=32, zero-wait slave, READB at 0x1003, DAT_I=0x80AA55CC -> SEL_O=4'b1000, ADR_O=0x1000, O_done 2 cycles after I_en, O_data=0xFFFFFF80. Same with READBU -> 0x00000080.
- DATA_W=64, WRITEH 0x1234 at 0x2006 -> SEL_O=8'hC0, DAT_O=0x1234123412341234, WE_O=1, ADR_O=0x2000, O_err=0.
- READW at 0x3002 -> no CYC_O pulse, O_done=O_err=1, code 1, two cycles after I_en.
- Slave asserts ERR_I and ACK_I together on the 3rd wait cycle -> code 2, O_data unchanged from the previous load.
- TIMEOUT=4, silent slave -> CYC_O high exactly 4 cycles, then code 3. A late ACK_I afterwards is ignored (no O_done).
- RST_N_I low on a BUS-state edge -> CYC_O/STB_O/O_busy 0 after that edge, no O_done. A subsequent READT sets TGA_O=1 and returns a 4-bit tag.

Source files
------------

// File: rtl/wb_cpu_bus_master.sv
// wb_cpu_bus_master: Wishbone B4 classic master for the CPU load/store unit
module wb_cpu_bus_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic                CLK_I,
  input  logic                RST_N_I,
  input  logic                I_en,
  input  logic [3:0]          I_op,
  input  logic [ADDR_W-1:0]   I_addr,
  input  logic [31:0]         I_data,
  output logic [31:0]         O_data,
  output logic                O_busy,
  output logic                O_done,
  output logic                O_err,
  output logic [1:0]          O_err_code,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  output logic                TGA_O,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic                ACK_I,
  input  logic                ERR_I
);
  localparam int SEL_W = DATA_W / 8;
  localparam int LSB_W = $clog2(SEL_W);
  localparam logic [3:0] BUSOP_READB  = 4'd0;
  localparam logic [3:0] BUSOP_READBU = 4'd1;
  localparam logic [3:0] BUSOP_READH  = 4'd2;
  localparam logic [3:0] BUSOP_READHU = 4'd3;
  localparam logic [3:0] BUSOP_READW  = 4'd4;
  localparam logic [3:0] BUSOP_READT  = 4'd5;
  localparam logic [3:0] BUSOP_WRITEB = 4'd8;
  localparam logic [3:0] BUSOP_WRITEH = 4'd9;
  localparam logic [3:0] BUSOP_WRITEW = 4'd10;
  localparam logic [3:0] BUSOP_WRITET = 4'd11;

  typedef enum logic [1:0] {IDLE, BUS, FAULT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [LSB_W-1:0]    lane_q, lane_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                we_q, we_d, tga_q, tga_d;
  logic [31:0]         data_q, data_d;
  logic                done_q, done_d, err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic                is_half, is_word, is_wr, is_tag, misal, to_hit, cyc;
  logic [LSB_W-1:0]    lane;
  logic [SEL_W-1:0]    req_sel;
  logic [DATA_W-1:0]   req_dat, sh;
  logic [31:0]         ld;

  assign lane    = I_addr[LSB_W-1:0];
  assign is_half = I_op inside {BUSOP_READH, BUSOP_READHU, BUSOP_WRITEH};
  assign is_word = I_op inside {BUSOP_READW, BUSOP_WRITEW};
  assign is_wr   = I_op inside {BUSOP_WRITEB, BUSOP_WRITEH, BUSOP_WRITEW, BUSOP_WRITET};
  assign is_tag  = I_op inside {BUSOP_READT, BUSOP_WRITET};
  assign misal   = (is_half & I_addr[0]) | (is_word & |I_addr[1:0]);
  assign req_sel = is_word ? SEL_W'(4'hF) << lane : is_half ? SEL_W'(2'b11) << lane : SEL_W'(1'b1) << lane;
  assign req_dat = is_tag  ? {SEL_W{4'h0, I_data[3:0]}} :
                   is_word ? {SEL_W/4{I_data}} :
                   is_half ? {SEL_W/2{I_data[15:0]}} : {SEL_W{I_data[7:0]}};

  // Load path: bring the addressed lane down to bit 0, then extend per op; unknown ops load a signed byte
  assign sh = DAT_I >> {lane_q, 3'b000};
  assign ld = op_q == BUSOP_READBU ? {24'b0, sh[7:0]} :
              op_q == BUSOP_READH  ? {{16{sh[15]}}, sh[15:0]} :
              op_q == BUSOP_READHU ? {16'b0, sh[15:0]} :
              op_q == BUSOP_READW  ? sh[31:0] :
              op_q == BUSOP_READT  ? {28'b0, sh[3:0]} : {{24{sh[7]}}, sh[7:0]};

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));
  assign cyc    = state_q == BUS;

  assign O_busy     = state_q != IDLE;
  assign CYC_O      = cyc;
  assign STB_O      = cyc;
  assign WE_O       = cyc & we_q;
  assign TGA_O      = cyc & tga_q;
  assign SEL_O      = cyc ? sel_q : '0;
  assign ADR_O      = adr_q;
  assign DAT_O      = dat_q;
  assign O_data     = data_q;
  assign O_done     = done_q;
  assign O_err      = err_q;
  assign O_err_code = code_q;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q <= IDLE;
      op_q    <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      tga_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      tga_q   <= tga_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next state: accept in IDLE, report misalignment from FAULT, terminate BUS on ERR > ACK > timeout
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    tga_d   = tga_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (state_q == IDLE && I_en) begin
      op_d   = I_op;
      lane_d = lane;
      adr_d  = {I_addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
      dat_d  = req_dat;
      sel_d  = req_sel;
      we_d   = is_wr;
      tga_d  = is_tag;
      if (misal) state_d = FAULT;
      else state_d = BUS;
    end else if (state_q == FAULT) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
      code_d  = 2'd1;
    end else if (state_q == BUS) begin
      if (ERR_I | ACK_I | to_hit) begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        err_d   = ERR_I | ~ACK_I;
        code_d  = ERR_I ? 2'd2 : ACK_I ? 2'd0 : 2'd3;
        if (ACK_I & ~ERR_I & ~we_q) data_d = ld;
      end else cnt_d = cnt_q + TO_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_cpu_bus_master.sv
// tb_wb_cpu_bus_master: directed bench with a transaction-level reference model
module tb_wb_cpu_bus_master;
  localparam int TO = 4;
  localparam logic [3:0] READB = 4'd0, READBU = 4'd1, READH = 4'd2, READHU = 4'd3, READW = 4'd4, READT = 4'd5;
  localparam logic [3:0] WRITEB = 4'd8, WRITEH = 4'd9, WRITEW = 4'd10, WRITET = 4'd11;

  logic clk = 1'b0, rst_n, en, ack, err, cmp_on;
  logic [3:0] op;
  logic [31:0] addr, wd, di, o_data, adr, dat;
  logic busy, done, o_err, cyc, stb, we, tga;
  logic [1:0] code;
  logic [3:0] sel;

  logic en6, ack6, err6;
  logic [3:0] op6;
  logic [31:0] addr6, wd6, o_data6, adr6;
  logic [63:0] di6, dat6;
  logic busy6, done6, o_err6, cyc6, stb6, we6, tga6;
  logic [1:0] code6;
  logic [7:0] sel6;

  int checks = 0, failures = 0;
  int lat, cyc_cnt;
  logic [3:0] obs_sel;
  logic [31:0] obs_adr, obs_dat, r_data;
  logic obs_we, obs_tga, obs_cyc, r_err;
  logic [1:0] r_code;

  logic m_busy, m_cyc, m_fault, m_we, m_tga, m_done, m_err;
  logic [3:0] m_sel, m_op;
  logic [31:0] m_adr, m_dat, m_data;
  logic [1:0] m_code, m_lane;
  int m_waits;

  always #5 clk = ~clk;

  wb_cpu_bus_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO), .TO_W(16)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .I_en(en), .I_op(op), .I_addr(addr), .I_data(wd),
    .O_data(o_data), .O_busy(busy), .O_done(done), .O_err(o_err), .O_err_code(code),
    .ADR_O(adr), .DAT_O(dat), .SEL_O(sel), .CYC_O(cyc), .STB_O(stb), .WE_O(we), .TGA_O(tga),
    .DAT_I(di), .ACK_I(ack), .ERR_I(err));

  wb_cpu_bus_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255), .TO_W(16)) dut64 (
    .CLK_I(clk), .RST_N_I(rst_n), .I_en(en6), .I_op(op6), .I_addr(addr6), .I_data(wd6),
    .O_data(o_data6), .O_busy(busy6), .O_done(done6), .O_err(o_err6), .O_err_code(code6),
    .ADR_O(adr6), .DAT_O(dat6), .SEL_O(sel6), .CYC_O(cyc6), .STB_O(stb6), .WE_O(we6), .TGA_O(tga6),
    .DAT_I(di6), .ACK_I(ack6), .ERR_I(err6));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [3:0] o);
    return (o == READH || o == READHU || o == WRITEH) ? 2 : (o == READW || o == WRITEW) ? 4 : 1;
  endfunction

  function automatic logic is_write(input logic [3:0] o);
    return o >= 4'd8 && o <= 4'd11;
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] o, input int ln, input logic [31:0] d);
    longint v;
    int n;
    logic sgn;
    n = nbytes(o);
    v = longint'(d) >> (8 * ln);
    v = v & ((64'd1 << (8 * n)) - 1);
    sgn = (o == READB || o == READH || (o > 4'd5 && o < 4'd8) || o > 4'd11);
    if (o == READT) v = v & 15;
    else if (sgn && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] store_val(input logic [3:0] o, input logic [31:0] w);
    logic [31:0] r;
    int n;
    n = nbytes(o);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = (o == WRITET) ? {4'h0, w[3:0]} : w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] sel_val(input logic [3:0] o, input int ln);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (i >= ln) && (i < ln + nbytes(o));
    return r;
  endfunction

  // Reference model: one transaction at a time, outputs derived from the request and slave response
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; m_cyc <= 0; m_fault <= 0; m_we <= 0; m_tga <= 0; m_done <= 0; m_err <= 0;
      m_sel <= 0; m_op <= 0; m_adr <= 0; m_dat <= 0; m_data <= 0; m_code <= 0; m_lane <= 0; m_waits <= 0;
    end else begin
      m_done <= 0;
      m_err <= 0;
      if (m_fault) begin
        m_fault <= 0; m_busy <= 0; m_done <= 1; m_err <= 1; m_code <= 1;
      end else if (m_cyc) begin
        if (err || ack || m_waits == TO - 1) begin
          m_cyc <= 0; m_busy <= 0; m_done <= 1; m_waits <= 0; m_sel <= 0; m_we <= 0; m_tga <= 0;
          m_err <= err || !ack;
          m_code <= err ? 2'd2 : ack ? 2'd0 : 2'd3;
          if (!err && ack && !is_write(m_op)) m_data <= load_val(m_op, int'(m_lane), di);
        end else m_waits <= m_waits + 1;
      end else if (en) begin
        m_busy <= 1;
        m_op <= op;
        m_lane <= addr[1:0];
        if (addr % nbytes(op) != 0) m_fault <= 1;
        else begin
          m_cyc <= 1;
          m_waits <= 0;
          m_sel <= sel_val(op, int'(addr[1:0]));
          m_adr <= addr & ~32'd3;
          m_dat <= store_val(op, wd);
          m_we <= is_write(op);
          m_tga <= op == READT || op == WRITET;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the 32-bit instance against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", busy, m_busy);
      chk("cyc", cyc, m_cyc);
      chk("stb", stb, m_cyc);
      chk("we", we, m_we);
      chk("tga", tga, m_tga);
      chk("sel", sel, m_sel);
      chk("done", done, m_done);
      chk("err", o_err, m_err);
      chk("code", code, m_code);
      chk("data", o_data, m_data);
      if (m_cyc) begin
        chk("adr", adr, m_adr);
        chk("dat", dat, m_dat);
      end
    end
  end

  // kind: 0 ACK after 'waits' wait cycles, 1 ERR+ACK together, 2 silent slave
  task automatic txn(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w, input logic [31:0] d,
                     input int waits, input int kind);
    en = 1; op = o; addr = a; wd = w; di = d; lat = 0; cyc_cnt = 0;
    @(negedge clk);
    en = 0; lat = 1;
    obs_sel = sel; obs_adr = adr; obs_dat = dat; obs_we = we; obs_tga = tga; obs_cyc = cyc;
    for (int k = 0; k < 20 && !done; k++) begin
      if (cyc) cyc_cnt++;
      ack = (kind != 2) && k == waits;
      err = (kind == 1) && k == waits;
      @(negedge clk);
      ack = 0; err = 0; lat++;
    end
    chk("done_seen", done, 1);
    r_err = o_err; r_code = code; r_data = o_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; en = 0; ack = 0; err = 0; op = 0; addr = 0; wd = 0; di = 0; cmp_on = 0;
    en6 = 0; ack6 = 0; err6 = 0; op6 = 0; addr6 = 0; wd6 = 0; di6 = 0;
    @(negedge clk);
    cmp_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_data", o_data, 0);
    chk("rst64_cyc", cyc6, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    txn(READB, 32'h1003, 0, 32'h80AA55CC, 0, 0);
    chk("rb_sel", obs_sel, 4'b1000);
    chk("rb_adr", obs_adr, 32'h1000);
    chk("rb_lat", lat, 2);
    chk("rb_data", r_data, 32'hFFFFFF80);
    chk("rb_err", r_err, 0);
    txn(READBU, 32'h1003, 0, 32'h80AA55CC, 0, 0);
    chk("rbu_data", r_data, 32'h00000080);
    txn(READH, 32'h1002, 0, 32'h80AA55CC, 0, 0);
    chk("rh_sel", obs_sel, 4'b1100);
    chk("rh_data", r_data, 32'hFFFF80AA);
    txn(READHU, 32'h1000, 0, 32'h80AA55CC, 1, 0);
    chk("rhu_lat", lat, 3);
    chk("rhu_data", r_data, 32'h000055CC);
    txn(READW, 32'h1000, 0, 32'h80AA55CC, 0, 0);
    chk("rw_sel", obs_sel, 4'hF);
    chk("rw_data", r_data, 32'h80AA55CC);
    txn(WRITEB, 32'h1001, 32'h5A, 0, 0, 0);
    chk("wb_sel", obs_sel, 4'b0010);
    chk("wb_dat", obs_dat, 32'h5A5A5A5A);
    chk("wb_we", obs_we, 1);
    chk("wb_data_held", r_data, 32'h80AA55CC);
    txn(WRITEW, 32'h3000, 32'hCAFEF00D, 0, 0, 0);
    chk("ww_dat", obs_dat, 32'hCAFEF00D);
    txn(WRITET, 32'h3002, 32'hF7, 0, 0, 0);
    chk("wt_dat", obs_dat, 32'h07070707);
    chk("wt_tga", obs_tga, 1);
    chk("wt_sel", obs_sel, 4'b0100);
    txn(READW, 32'h3002, 0, 32'h11111111, 0, 2);
    chk("mis_cyc", obs_cyc, 0);
    chk("mis_cyc_cnt", cyc_cnt, 0);
    chk("mis_lat", lat, 2);
    chk("mis_err", r_err, 1);
    chk("mis_code", r_code, 1);
    txn(READH, 32'h1001, 0, 0, 0, 2);
    chk("mish_code", r_code, 1);
    txn(READBU, 32'h1003, 0, 32'h80AA55CC, 0, 0);
    txn(READW, 32'h0010, 0, 32'h11111111, 2, 1);
    chk("berr_code", r_code, 2);
    chk("berr_err", r_err, 1);
    chk("berr_data_held", r_data, 32'h00000080);
    txn(READW, 32'h0020, 0, 32'h22222222, 0, 2);
    chk("to_cyc_cnt", cyc_cnt, TO);
    chk("to_lat", lat, TO + 1);
    chk("to_code", r_code, 3);
    chk("to_err", r_err, 1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("late_ack_done", done, 0);
    chk("late_ack_busy", busy, 0);
    en = 1; op = READW; addr = 32'h40; di = 0;
    @(negedge clk);
    en = 0;
    chk("pre_rst_cyc", cyc, 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_cyc", cyc, 0);
    chk("mid_rst_stb", stb, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    txn(READT, 32'h1001, 0, 32'h12345B78, 0, 0);
    chk("rt_tga", obs_tga, 1);
    chk("rt_sel", obs_sel, 4'b0010);
    chk("rt_data", r_data, 32'h0000000B);
    txn(4'hF, 32'h1002, 0, 32'h00800000, 0, 0);
    chk("unk_we", obs_we, 0);
    chk("unk_sel", obs_sel, 4'b0100);
    chk("unk_data", r_data, 32'hFFFFFF80);

    en6 = 1; op6 = WRITEH; addr6 = 32'h2006; wd6 = 32'h1234;
    @(negedge clk);
    en6 = 0;
    chk("w64_cyc", cyc6, 1);
    chk("w64_sel", sel6, 8'hC0);
    chk("w64_dat", dat6, 64'h1234123412341234);
    chk("w64_we", we6, 1);
    chk("w64_adr", adr6, 32'h2000);
    ack6 = 1;
    @(negedge clk);
    ack6 = 0;
    chk("w64_done", done6, 1);
    chk("w64_err", o_err6, 0);
    en6 = 1; op6 = READW; addr6 = 32'h2004; di6 = 64'hDEADBEEF_00000000;
    @(negedge clk);
    en6 = 0;
    chk("r64_sel", sel6, 8'hF0);
    ack6 = 1;
    @(negedge clk);
    ack6 = 0;
    chk("r64_done", done6, 1);
    chk("r64_data", o_data6, 32'hDEADBEEF);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
